// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Provides the register address width, the arbiter state encoding and
// the default sizing parameters used by the top and its FIFO.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W       = 5;
  localparam int unsigned DEFAULT_XLEN     = 32;
  localparam int unsigned DEFAULT_DEPTH    = 4;
  localparam int unsigned DEFAULT_MAX_WAIT = 8;

  // Records which source won the RF write port in the last cycle.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EX    = 2'd1,
    S_MEM   = 2'd2,
    S_FORCE = 2'd3
  } wb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Load-return buffer: synchronous DEPTH x WIDTH FIFO.
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-low reset
//   push, wdata     write request and entry
//   pop, rdata      read request and head entry (rdata valid when !empty)
//   full, empty     occupancy flags from the registered count
//   count           registered number of stored entries
// Push and pop in the same cycle are allowed at any occupancy, including full.
module regfile_wb_arbiter_wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
    do_push  = push && (!full || do_pop);
    // Pointers wrap by natural overflow (DEPTH is a power of two).
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the count makes stale entries invisible.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter.
// Shares the single RF write port (A3/WD/WE) between execute writeback and
// load returns. Load returns are buffered in a FIFO and drained into free
// slots; a head that waits too long, or a full FIFO with another return
// pending, forces a drain and stalls execute. A scoreboard tracks registers
// with outstanding loads for hazard lookups.
// Ports:
//   CLK, RST                       clock, asynchronous active-low reset
//   ex_valid/ex_rd/ex_data         execute writeback request
//   ex_stall                       execute must hold its request this cycle
//   mem_valid/mem_rd/mem_data      load return; mem_ready = FIFO not full
//   lsu_issue/lsu_rd               load issued, marks lsu_rd busy
//   rs1/rs2/rd_addr -> *_busy      outstanding-load hazard lookups
//   A3/WD/WE                       registered RF write (one cycle after grant)
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned XLEN     = DEFAULT_XLEN,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       ex_data,
  output logic                  ex_stall,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  mem_ready,
  input  logic                  lsu_issue,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rd_busy,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [XLEN-1:0]       WD,
  output logic                  WE
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned AGE_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned ENT_W = REG_ADDR_W + XLEN;
  localparam logic [AGE_W-1:0] AGE_FORCE = AGE_W'(MAX_WAIT - 1);
  localparam logic [AGE_W-1:0] AGE_SAT   = AGE_W'(MAX_WAIT);
  localparam logic [AGE_W-1:0] AGE_ONE   = AGE_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

  wb_state_e             state_q, state_d;
  logic [AGE_W-1:0]      age_q, age_d;
  logic [31:0]           busy_q, busy_d;
  logic [REG_ADDR_W-1:0] a3_q, a3_d;
  logic [XLEN-1:0]       wd_q, wd_d;
  logic                  we_q, we_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [ENT_W-1:0]      fifo_rdata;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  force_grant, grant;
  logic [REG_ADDR_W-1:0] grant_rd;
  logic [XLEN-1:0]       grant_data;

  regfile_wb_arbiter_wb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (fifo_push),
    .wdata ({mem_rd, mem_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_rd, head_data} = fifo_rdata;
  assign mem_ready = (fifo_count != CNT_FULL);
  assign fifo_push = mem_valid && mem_ready;
  assign ex_stall  = force_grant;

  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];
  assign rd_busy  = busy_q[rd_addr];

  assign A3 = a3_q;
  assign WD = wd_q;
  assign WE = we_q;

  always_comb begin
    // A forced grant always resets age and leaves the FIFO below full, so the
    // S_FORCE guard only enforces a single forced grant per entry into S_FORCE.
    force_grant = !fifo_empty && (state_q != S_FORCE) &&
                  ((age_q >= AGE_FORCE) || (fifo_full && mem_valid));
    state_d    = S_IDLE;
    fifo_pop   = 1'b0;
    grant      = 1'b0;
    grant_rd   = '0;
    grant_data = '0;
    if (force_grant) begin
      state_d    = S_FORCE;
      fifo_pop   = 1'b1;
      grant      = 1'b1;
      grant_rd   = head_rd;
      grant_data = head_data;
    end else if (ex_valid) begin
      state_d    = S_EX;
      grant      = 1'b1;
      grant_rd   = ex_rd;
      grant_data = ex_data;
    end else if (!fifo_empty) begin
      state_d    = S_MEM;
      fifo_pop   = 1'b1;
      grant      = 1'b1;
      grant_rd   = head_rd;
      grant_data = head_data;
    end

    // x0 grants still consume their slot but never write.
    we_d = grant && (grant_rd != '0);
    a3_d = grant ? grant_rd : a3_q;
    wd_d = grant ? grant_data : wd_q;

    age_d = age_q;
    if (fifo_empty || fifo_pop) begin
      age_d = '0;
    end else if (age_q != AGE_SAT) begin
      age_d = age_q + AGE_ONE;
    end

    // Clear before set so an issue to the same register in the same cycle wins.
    busy_d = busy_q;
    if (fifo_pop) begin
      busy_d[head_rd] = 1'b0;
    end
    if (lsu_issue) begin
      busy_d[lsu_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      age_q   <= '0;
      busy_q  <= '0;
      a3_q    <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      busy_q  <= busy_d;
      a3_q    <= a3_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
    end
  end

endmodule
